// File: rtl/ex_pkg.sv
// Shared constants for the ex issue controller.
// State encoding and register-file geometry.
package ex_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LS    = 2'd1;
    localparam logic [1:0] ST_BRW   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam int NREGS = 16;
    localparam int RW    = $clog2(NREGS);

endpackage

// File: rtl/ex_scoreboard.sv
// Pending-write scoreboard: one bit per register,
// set on issue, cleared on write-back, set wins.
module ex_scoreboard
    import ex_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [RW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [RW-1:0] clr_addr,
    input  logic [RW-1:0] rd_addr,
    input  logic [RW-1:0] rs_addr,
    output logic          rd_pend,
    output logic          rs_pend
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask = NREGS'(1) << set_addr;
        if (clr_en) clr_mask = NREGS'(1) << clr_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) pend <= '0;
        else     pend <= (pend & ~clr_mask) | set_mask;
    end

    // Lookups see the registered value only: no write-back bypass.
    assign rd_pend = pend[rd_addr];
    assign rs_pend = pend[rs_addr];

endmodule

// File: rtl/ex_issue_ctrl.sv
// Issue controller between decode and ex: hazard check,
// load/store occupancy and branch-resolve/flush sequencing.
module ex_issue_ctrl
    import ex_pkg::*;
#(
    parameter int LS_CYCLES    = 2,
    parameter int FLUSH_CYCLES = 2
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          dec_v_i,
    input  logic [RW-1:0] dec_rd_addr_i,
    input  logic [RW-1:0] dec_rs_addr_i,
    input  logic          dec_rd_rd_i,
    input  logic          dec_rs_rd_i,
    input  logic          dec_wb_i,
    input  logic          dec_ld_i,
    input  logic          dec_st_i,
    input  logic          dec_br_i,
    input  logic          ex_branch_en_i,
    input  logic          ex_wb_en_i,
    input  logic [RW-1:0] ex_rd_addr_i,
    output logic          ex_v_o,
    output logic          dec_stall_o,
    output logic          flush_o,
    output logic [1:0]    state_o
);

    localparam int CMAX = (LS_CYCLES > FLUSH_CYCLES) ? LS_CYCLES
                                                     : FLUSH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] LS_INIT = CW'(LS_CYCLES - 1);
    localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYCLES);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          rd_pend;
    logic          rs_pend;
    logic          hazard;
    logic          issue;

    ex_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue & dec_wb_i),
        .set_addr (dec_rd_addr_i),
        .clr_en   (ex_wb_en_i),
        .clr_addr (ex_rd_addr_i),
        .rd_addr  (dec_rd_addr_i),
        .rs_addr  (dec_rs_addr_i),
        .rd_pend  (rd_pend),
        .rs_pend  (rs_pend)
    );

    // Third term blocks WAW on a still-pending destination.
    assign hazard = (dec_rd_rd_i & rd_pend)
                  | (dec_rs_rd_i & rs_pend)
                  | (dec_wb_i    & rd_pend);

    assign issue = ~rst & (state == ST_RUN) & dec_v_i & ~hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            ST_RUN: begin
                if (issue) begin
                    if ((dec_ld_i | dec_st_i) && LS_CYCLES > 1) begin
                        state_n = ST_LS;
                        cnt_n   = LS_INIT;
                    end else if (dec_br_i) begin
                        state_n = ST_BRW;
                    end
                end
            end
            ST_LS, ST_FLUSH: begin
                if (cnt == ONE) state_n = ST_RUN;
                else            cnt_n   = cnt - ONE;
            end
            ST_BRW: begin
                if (ex_branch_en_i) begin
                    state_n = ST_FLUSH;
                    cnt_n   = FL_INIT;
                end else begin
                    state_n = ST_RUN;
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_comb begin
        ex_v_o      = 1'b0;
        dec_stall_o = 1'b0;
        flush_o     = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_RUN: begin
                    ex_v_o      = dec_v_i & ~hazard;
                    dec_stall_o = dec_v_i & hazard;
                end
                ST_LS:    dec_stall_o = 1'b1;
                ST_BRW:   dec_stall_o = 1'b1;
                ST_FLUSH: flush_o     = 1'b1;
                default:  ;
            endcase
        end
    end

    assign state_o = rst ? ST_RUN : state;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Bench for ex_issue_ctrl: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_ex_issue_ctrl;

    localparam int LS  = 3;
    localparam int FL  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_v_i;
    logic [3:0] dec_rd_addr_i;
    logic [3:0] dec_rs_addr_i;
    logic       dec_rd_rd_i;
    logic       dec_rs_rd_i;
    logic       dec_wb_i;
    logic       dec_ld_i;
    logic       dec_st_i;
    logic       dec_br_i;
    logic       ex_branch_en_i;
    logic       ex_wb_en_i;
    logic [3:0] ex_rd_addr_i;
    logic       ex_v_o;
    logic       dec_stall_o;
    logic       flush_o;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_issue_ctrl #(.LS_CYCLES(LS), .FLUSH_CYCLES(FL)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_v_i        (dec_v_i),
        .dec_rd_addr_i  (dec_rd_addr_i),
        .dec_rs_addr_i  (dec_rs_addr_i),
        .dec_rd_rd_i    (dec_rd_rd_i),
        .dec_rs_rd_i    (dec_rs_rd_i),
        .dec_wb_i       (dec_wb_i),
        .dec_ld_i       (dec_ld_i),
        .dec_st_i       (dec_st_i),
        .dec_br_i       (dec_br_i),
        .ex_branch_en_i (ex_branch_en_i),
        .ex_wb_en_i     (ex_wb_en_i),
        .ex_rd_addr_i   (ex_rd_addr_i),
        .ex_v_o         (ex_v_o),
        .dec_stall_o    (dec_stall_o),
        .flush_o        (flush_o),
        .state_o        (state_o)
    );

    task automatic idle();
        dec_v_i        = 1'b0;
        dec_rd_addr_i  = '0;
        dec_rs_addr_i  = '0;
        dec_rd_rd_i    = 1'b0;
        dec_rs_rd_i    = 1'b0;
        dec_wb_i       = 1'b0;
        dec_ld_i       = 1'b0;
        dec_st_i       = 1'b0;
        dec_br_i       = 1'b0;
        ex_branch_en_i = 1'b0;
        ex_wb_en_i     = 1'b0;
        ex_rd_addr_i   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] rd, input logic [3:0] rs,
                       input logic rsrd, input logic wb);
        idle();
        dec_v_i       = 1'b1;
        dec_rd_addr_i = rd;
        dec_rs_addr_i = rs;
        dec_rs_rd_i   = rsrd;
        dec_wb_i      = wb;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        alu(4'd1, 4'd2, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (ex_v_o !== 1'b0 || dec_stall_o !== 1'b0 ||
                flush_o !== 1'b0 || state_o !== 2'd0) begin
                errors++;
                $display("FAIL reset_outs: v=%b stall=%b flush=%b st=%0d req 0",
                         ex_v_o, dec_stall_o, flush_o, state_o);
            end
            next_cycle();
        end
        checks++;
        if (dut.u_sb.pend !== 16'h0) begin
            errors++;
            $display("FAIL reset_pend: got %h req 0000", dut.u_sb.pend);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_issue: got %b req 1", ex_v_o);
        end
        next_cycle();
    endtask

    task automatic test_raw();
        pulse_reset();
        alu(4'd3, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1) begin
            errors++;
            $display("FAIL raw_c0: ex_v=%b req 1", ex_v_o);
        end
        next_cycle();
        alu(4'd4, 4'd3, 1'b1, 1'b1);
        ex_wb_en_i   = 1'b1;
        ex_rd_addr_i = 4'd3;
        @(negedge clk);
        checks++;
        if (dec_stall_o !== 1'b1 || ex_v_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_c1: stall=%b ex_v=%b req 1/0",
                     dec_stall_o, ex_v_o);
        end
        next_cycle();
        ex_wb_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1 || dec_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL raw_c2: ex_v=%b stall=%b req 1/0",
                     ex_v_o, dec_stall_o);
        end
        next_cycle();
    endtask

    task automatic test_load();
        pulse_reset();
        alu(4'd6, 4'd0, 1'b0, 1'b1);
        dec_ld_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1) begin
            errors++;
            $display("FAIL ld_c0: ex_v=%b req 1", ex_v_o);
        end
        next_cycle();
        alu(4'd7, 4'd1, 1'b1, 1'b0);
        for (int i = 1; i < LS; i++) begin
            @(negedge clk);
            checks++;
            if (dec_stall_o !== 1'b1 || state_o !== 2'd1 ||
                ex_v_o !== 1'b0) begin
                errors++;
                $display("FAIL ld_c%0d: stall=%b st=%0d ex_v=%b req 1/1/0",
                         i, dec_stall_o, state_o, ex_v_o);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL ld_resume: ex_v=%b st=%0d req 1/0",
                     ex_v_o, state_o);
        end
        next_cycle();
    endtask

    task automatic test_branch(input logic taken);
        pulse_reset();
        alu(4'd2, 4'd0, 1'b0, 1'b0);
        dec_br_i = 1'b1;
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1) begin
            errors++;
            $display("FAIL br%0b_c0: ex_v=%b req 1", taken, ex_v_o);
        end
        next_cycle();
        alu(4'd8, 4'd9, 1'b1, 1'b1);
        ex_branch_en_i = taken;
        @(negedge clk);
        checks++;
        if (state_o !== 2'd2 || dec_stall_o !== 1'b1 ||
            ex_v_o !== 1'b0 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL br%0b_c1: st=%0d stall=%b v=%b fl=%b req 2/1/0/0",
                     taken, state_o, dec_stall_o, ex_v_o, flush_o);
        end
        next_cycle();
        ex_branch_en_i = 1'b1;
        if (taken) begin
            for (int i = 0; i < FL; i++) begin
                @(negedge clk);
                checks++;
                if (flush_o !== 1'b1 || ex_v_o !== 1'b0 ||
                    dec_stall_o !== 1'b0 || state_o !== 2'd3) begin
                    errors++;
                    $display("FAIL br_flush%0d: fl=%b v=%b stall=%b st=%0d",
                             i, flush_o, ex_v_o, dec_stall_o, state_o);
                end
                next_cycle();
            end
        end
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL br%0b_resume: ex_v=%b flush=%b req 1/0",
                     taken, ex_v_o, flush_o);
        end
        next_cycle();
        idle();
    endtask

    task automatic test_collision();
        pulse_reset();
        alu(4'd5, 4'd0, 1'b0, 1'b1);
        next_cycle();
        idle();
        ex_wb_en_i   = 1'b1;
        ex_rd_addr_i = 4'd5;
        next_cycle();
        alu(4'd5, 4'd0, 1'b0, 1'b1);
        ex_wb_en_i   = 1'b1;
        ex_rd_addr_i = 4'd5;
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1) begin
            errors++;
            $display("FAIL coll_issue: ex_v=%b req 1", ex_v_o);
        end
        next_cycle();
        checks++;
        if (dut.u_sb.pend[5] !== 1'b1) begin
            errors++;
            $display("FAIL coll_pend5: got %b req 1", dut.u_sb.pend[5]);
        end
        alu(4'd1, 4'd5, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (dec_stall_o !== 1'b1 || ex_v_o !== 1'b0) begin
                errors++;
                $display("FAIL coll_stall%0d: stall=%b v=%b req 1/0",
                         i, dec_stall_o, ex_v_o);
            end
            if (i == 1) begin
                ex_wb_en_i   = 1'b1;
                ex_rd_addr_i = 4'd5;
            end
            next_cycle();
        end
        ex_wb_en_i = 1'b0;
        @(negedge clk);
        checks++;
        if (ex_v_o !== 1'b1) begin
            errors++;
            $display("FAIL coll_release: ex_v=%b req 1", ex_v_o);
        end
        next_cycle();
    endtask

    // Model: pending set plus "cycles left" counters per activity.
    task automatic test_random();
        bit [15:0] pend_m;
        int        ls_left;
        bit        br_wait;
        int        fl_left;
        bit        haz;
        bit        iss;
        logic      e_v;
        logic      e_stall;
        logic      e_fl;
        logic [1:0] e_st;
        int        cls;
        pulse_reset();
        pend_m  = '0;
        ls_left = 0;
        br_wait = 1'b0;
        fl_left = 0;
        for (int n = 0; n < 500; n++) begin
            idle();
            rst            = ($urandom_range(0, 49) == 0);
            dec_v_i        = ($urandom_range(0, 9) < 7);
            dec_rd_addr_i  = 4'($urandom_range(0, 15));
            dec_rs_addr_i  = 4'($urandom_range(0, 15));
            dec_rd_rd_i    = 1'($urandom_range(0, 1));
            dec_rs_rd_i    = 1'($urandom_range(0, 1));
            dec_wb_i       = 1'($urandom_range(0, 1));
            cls            = $urandom_range(0, 9);
            dec_ld_i       = (cls == 0);
            dec_st_i       = (cls == 1);
            dec_br_i       = (cls == 2);
            ex_branch_en_i = 1'($urandom_range(0, 1));
            ex_wb_en_i     = ($urandom_range(0, 9) < 5);
            ex_rd_addr_i   = 4'($urandom_range(0, 15));

            haz = (dec_rd_rd_i && pend_m[dec_rd_addr_i]) ||
                  (dec_rs_rd_i && pend_m[dec_rs_addr_i]) ||
                  (dec_wb_i && pend_m[dec_rd_addr_i]);
            e_v = 0; e_stall = 0; e_fl = 0; e_st = 2'd0; iss = 0;
            if (rst) begin
                e_st = 2'd0;
            end else if (ls_left > 0) begin
                e_stall = 1; e_st = 2'd1;
            end else if (br_wait) begin
                e_stall = 1; e_st = 2'd2;
            end else if (fl_left > 0) begin
                e_fl = 1; e_st = 2'd3;
            end else begin
                iss     = dec_v_i && !haz;
                e_v     = iss;
                e_stall = dec_v_i && haz;
            end

            @(negedge clk);
            checks++;
            if (ex_v_o !== e_v || dec_stall_o !== e_stall ||
                flush_o !== e_fl || state_o !== e_st) begin
                errors++;
                $display("FAIL rand_%0d: v/stall/fl/st=%b%b%b/%0d req %b%b%b/%0d",
                         n, ex_v_o, dec_stall_o, flush_o, state_o,
                         e_v, e_stall, e_fl, e_st);
            end
            next_cycle();

            if (rst) begin
                pend_m = '0; ls_left = 0; br_wait = 0; fl_left = 0;
            end else begin
                if (ls_left > 0) begin
                    ls_left--;
                end else if (br_wait) begin
                    br_wait = 0;
                    if (ex_branch_en_i) fl_left = FL;
                end else if (fl_left > 0) begin
                    fl_left--;
                end else if (iss) begin
                    if (dec_ld_i || dec_st_i) ls_left = LS - 1;
                    else if (dec_br_i)        br_wait = 1;
                end
                if (ex_wb_en_i)     pend_m[ex_rd_addr_i]  = 1'b0;
                if (iss && dec_wb_i) pend_m[dec_rd_addr_i] = 1'b1;
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_raw();
        test_load();
        test_branch(1'b1);
        test_branch(1'b0);
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
